sim_clock_ctrl: RTL
===================

SIM_CLOCK_CTRL -- requirements
Module: sim_clock_ctrl

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 4, number of cycles gate_rst is held after init.
REQ-002 SHALL have parameter CNT_W, default 16, width of step_count and remaining-step counter.
REQ-003 SHALL have parameter TICK_W, default 32, width of tick_cnt.
REQ-004 clk  input  1  single clock; gate fabric computes next values on falling edge and updates outputs on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 init_req  input  1  one-cycle pulse: reload all gates to initial values.
REQ-007 run  input  1  level: free-run gate fabric while high.
REQ-008 halt  input  1  one-cycle pulse: stop fabric, abort any step burst.
REQ-009 step_req  input  1  one-cycle pulse: advance fabric step_count evaluations.
REQ-010 step_count  input  CNT_W  burst length, sampled when step_req is accepted.
REQ-011 gate_ce  output  1  fabric enable; one high cycle = one gate evaluation.
REQ-012 gate_rst  output  1  active-high reset to fabric; forces gates to initial value.
REQ-013 busy  output  1  high in INIT, RUN, STEP.
REQ-014 done  output  1  one-cycle pulse at normal end of step burst or INIT.
REQ-015 aborted  output  1  one-cycle pulse when halt or init_req ends a STEP burst early.
REQ-016 tick_cnt  output  TICK_W  count of gate_ce-high cycles since last init.

Function
REQ-017 SHALL implement states INIT, IDLE, RUN, STEP, registered, one-hot or binary.
REQ-018 Request priority per cycle SHALL be init_req > halt > run > step_req.
REQ-019 INIT: gate_rst=1, gate_ce=0 for exactly INIT_CYCLES cycles, then done pulse, -> IDLE.
REQ-020 IDLE: gate_ce=0; run=1 -> RUN; step_req with step_count>0 -> STEP; step_req with step_count=0 -> stay IDLE, done pulse next cycle, no gate_ce.
REQ-021 RUN: gate_ce=1 every cycle; run=0 or halt -> IDLE, gate_ce low from next cycle.
REQ-022 STEP: gate_ce=1 for exactly step_count consecutive cycles; done pulses in the cycle after the last gate_ce, with state back in IDLE.
REQ-023 Latency: request sampled at rising edge k SHALL give first gate_ce high in cycle k+1.
REQ-024 In STEP, run and step_req SHALL be ignored (not queued).
REQ-025 halt in STEP SHALL drop gate_ce next cycle, pulse aborted, -> IDLE; halt in IDLE/INIT ignored.
REQ-026 init_req in any state SHALL enter INIT next cycle, restart INIT count, clear tick_cnt; pulse aborted if leaving STEP.
REQ-027 tick_cnt SHALL increment by 1 on each gate_ce-high cycle, wrapping modulo 2^TICK_W without flag.
REQ-028 done and aborted SHALL never be high in the same cycle; gate_ce and gate_rst SHALL never be high together.
REQ-029 All outputs SHALL be registered (no combinational path input->output).

Reset
REQ-030 rst low SHALL asynchronously force state INIT, INIT counter 0, tick_cnt 0, gate_ce 0, gate_rst 1, busy 1, done 0, aborted 0.
REQ-031 After rst rises, INIT SHALL run its full INIT_CYCLES sequence with no request needed.

Structure
REQ-032 State encoding constants and default INIT_CYCLES SHALL live in shared package sim_ctrl_pkg.
REQ-033 Remaining-step/INIT countdown SHALL be one sub-module, down_counter (load, dec, zero flag).

Verification
REQ-034 Reset release, INIT_CYCLES=4 -> gate_rst high 4 cycles, done pulse in cycle 5, tick_cnt=0.
REQ-035 step_req with step_count=3 in IDLE -> gate_ce high cycles k+1..k+3, done at k+4, tick_cnt +3.
REQ-036 step_req step_count=0 -> no gate_ce, done at k+1, tick_cnt unchanged.
REQ-037 step_count=10, halt at 4th gate_ce cycle -> gate_ce low next cycle, aborted pulse, no done, tick_cnt +4.
REQ-038 run high 5 cycles with simultaneous step_req -> RUN wins, gate_ce 5 cycles, step ignored.
REQ-039 Preset tick_cnt near 2^TICK_W-1 (TICK_W=4 build), 3 steps -> tick_cnt wraps to 1; init_req mid-RUN -> gate_rst next cycle, tick_cnt 0.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation clock controller.
//   state_t          controller state encoding (INIT, IDLE, RUN, STEP)
//   INIT_CYCLES_DEF  default number of cycles gate_rst is held in INIT
package sim_ctrl_pkg;

  localparam int unsigned INIT_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

endpackage

// File: rtl/sim_clock_ctrl_if.sv
// Request/status bundle between a host and the simulation clock controller.
//   init_req, run, halt, step_req, step_count   host -> controller
//   gate_ce, gate_rst, busy, done, aborted,
//   tick_cnt                                     controller -> host/fabric
// master = host side, slave = controller side.
interface sim_clock_ctrl_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned TICK_W = 32
);
  logic              init_req;
  logic              run;
  logic              halt;
  logic              step_req;
  logic [CNT_W-1:0]  step_count;
  logic              gate_ce;
  logic              gate_rst;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [TICK_W-1:0] tick_cnt;

  modport master (
    output init_req, run, halt, step_req, step_count,
    input  gate_ce, gate_rst, busy, done, aborted, tick_cnt
  );

  modport slave (
    input  init_req, run, halt, step_req, step_count,
    output gate_ce, gate_rst, busy, done, aborted, tick_cnt
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter shared by the INIT hold and the step burst.
//   clk, rst     clock, asynchronous active-low reset (count -> 0)
//   load_i       load load_val_i (wins over dec_i)
//   dec_i        decrement by one, saturating at zero
//   count_o      current count
//   zero_o       count is zero
module down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);
endmodule

// File: rtl/sim_clock_ctrl.sv
// Simulation clock controller: gates a fabric clock enable for INIT, free
// RUN and counted STEP bursts. All outputs are registered.
//   clk   single clock
//   rst   asynchronous active-low reset (forces INIT)
//   ctl   sim_clock_ctrl_if.slave: requests in, gate_ce/gate_rst/busy/
//         done/aborted/tick_cnt out
module sim_clock_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TICK_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  sim_clock_ctrl_if.slave      ctl
);
  // INIT starts with the counter at zero (reset or init_req), reloads it on
  // its first cycle and ends on the cycle the count reaches one; this keeps
  // the counter's reset value at zero while still giving INIT_CYCLES cycles.
  localparam bit               INIT_SHORT  = (INIT_CYCLES <= 1);
  localparam logic [CNT_W-1:0] INIT_RELOAD = (INIT_CYCLES > 1) ? CNT_W'(INIT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val, cnt;
  logic              init_last;

  logic              gate_ce_q, gate_ce_d;
  logic              gate_rst_q, gate_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  down_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_val),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  assign init_last = (cnt == CNT_W'(1)) || (cnt_zero && INIT_SHORT);

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    if (ctl.init_req) begin
      state_d   = ST_INIT;
      cnt_load  = 1'b1;
      aborted_d = (state_q == ST_STEP);
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (init_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = INIT_RELOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_IDLE: begin
          if (ctl.run) begin
            state_d = ST_RUN;
          end else if (ctl.step_req) begin
            if (ctl.step_count == '0) begin
              done_d = 1'b1;
            end else begin
              // Counter holds the evaluations remaining after the current one.
              state_d  = ST_STEP;
              cnt_load = 1'b1;
              cnt_val  = ctl.step_count - CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (ctl.halt || !ctl.run) state_d = ST_IDLE;
        end
        ST_STEP: begin
          if (ctl.halt) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
          end else if (cnt_zero) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    gate_ce_d  = (state_d == ST_RUN) || (state_d == ST_STEP);
    gate_rst_d = (state_d == ST_INIT);
    busy_d     = (state_d != ST_IDLE);
    tick_d     = ctl.init_req ? '0 : tick_q + TICK_W'(gate_ce_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      gate_ce_q  <= 1'b0;
      gate_rst_q <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      tick_q     <= '0;
    end else begin
      state_q    <= state_d;
      gate_ce_q  <= gate_ce_d;
      gate_rst_q <= gate_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      tick_q     <= tick_d;
    end
  end

  assign ctl.gate_ce  = gate_ce_q;
  assign ctl.gate_rst = gate_rst_q;
  assign ctl.busy     = busy_q;
  assign ctl.done     = done_q;
  assign ctl.aborted  = aborted_q;
  assign ctl.tick_cnt = tick_q;
endmodule
